// File: rtl/eth_reg_responder.sv
// Host-bus register responder: 64 x 32-bit byte-laned storage, a CHIP_ID word,
// a 16-deep RX FIFO read through DATA_PORT and a TX word written through it.
module eth_reg_responder #(
  parameter logic [7:0]  DATA_PORT = 8'hD8,
  parameter logic [15:0] CHIP_ID   = 16'h8872
) (
  input  logic        clk40m,
  input  logic        reset,
  input  logic        CMD,
  input  logic        RDN,
  input  logic        WRN,
  inout  wire  [15:0] SD,
  input  logic        rx_push,
  input  logic [15:0] rx_data,
  output logic [4:0]  rx_level,
  output logic        rx_full,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  output logic [15:0] last_addr,
  output logic        err_underflow,
  output logic        be_err
);

  localparam logic [7:0] CHIP_OFS = 8'hC0;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100: be_legal = 1'b1;
      default: be_legal = 1'b0;
    endcase
  endfunction

  logic        cmd_r, wrn_r, wrn_d_r, rdn_r, rdn_d_r, wr_cmd_r, rd_ok_r, be_bad_r;
  logic [15:0] sd_r, wr_sd_r, rd_data_r;
  logic [31:0] mem_r [64];
  logic [15:0] fifo_r [16];
  logic [3:0]  wptr_r, rptr_r;

  logic        wr_stb_s, addr_stb_s, data_wr_s, rd_stb_s, pop_s, push_s, underflow_s;
  logic        hi_s, lo_en_s, hi_en_s;
  logic [3:0]  be_s;
  logic [5:0]  idx_s;
  logic [7:0]  offset_s;
  logic [4:0]  level_nxt_s;
  logic [31:0] dword_s;
  logic [15:0] word_s, rd_word_s;

  assign be_s        = last_addr[15:12];
  assign idx_s       = last_addr[7:2];
  assign hi_s        = be_s[2] | be_s[3];
  assign offset_s    = {idx_s, 1'b0, hi_s};
  assign lo_en_s     = hi_s ? be_s[2] : be_s[0];
  assign hi_en_s     = hi_s ? be_s[3] : be_s[1];
  assign wr_stb_s    = wrn_r & ~wrn_d_r;
  assign addr_stb_s  = wr_stb_s & wr_cmd_r;
  assign data_wr_s   = wr_stb_s & ~wr_cmd_r & ~be_bad_r;
  assign rd_stb_s    = rdn_r & ~rdn_d_r & rd_ok_r & ~be_bad_r & (offset_s == DATA_PORT);
  assign pop_s       = rd_stb_s & (rx_level != 5'd0);
  assign underflow_s = rd_stb_s & (rx_level == 5'd0);
  assign push_s      = rx_push & (~rx_full | pop_s);
  assign level_nxt_s = rx_level + {4'b0000, push_s} - {4'b0000, pop_s};

  // A simultaneous write strobe wins over the read, so SD stays released then.
  assign SD = (reset && !RDN && !CMD && WRN) ? rd_data_r : 16'hzzzz;

  // Bus input capture; strobe payload is frozen from the last cycle the strobe was low.
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      cmd_r    <= 1'b0;
      wrn_r    <= 1'b1;
      wrn_d_r  <= 1'b1;
      rdn_r    <= 1'b1;
      rdn_d_r  <= 1'b1;
      sd_r     <= 16'h0000;
      wr_sd_r  <= 16'h0000;
      wr_cmd_r <= 1'b0;
      rd_ok_r  <= 1'b0;
    end else begin
      cmd_r   <= CMD;
      wrn_r   <= WRN;
      wrn_d_r <= wrn_r;
      rdn_r   <= RDN;
      rdn_d_r <= rdn_r;
      sd_r    <= SD;
      if (!wrn_r) begin
        wr_sd_r  <= sd_r;
        wr_cmd_r <= cmd_r;
      end
      if (rdn_r) rd_ok_r <= 1'b1;
      else       rd_ok_r <= rd_ok_r & ~cmd_r & wrn_r;
    end
  end

  // Read word selection with byte-lane masking.
  always_comb begin
    dword_s = mem_r[idx_s];
    if (offset_s == DATA_PORT) begin
      word_s = (rx_level != 5'd0) ? fifo_r[rptr_r] : 16'h0000;
    end else if (hi_s) begin
      word_s = dword_s[31:16];
    end else begin
      word_s = dword_s[15:0];
    end
    if (be_bad_r) begin
      rd_word_s = 16'h0000;
    end else begin
      rd_word_s = {(hi_en_s ? word_s[15:8] : 8'h00), (lo_en_s ? word_s[7:0] : 8'h00)};
    end
  end

  // Control, status and TX registers.
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      last_addr     <= 16'h0000;
      be_bad_r      <= 1'b0;
      be_err        <= 1'b0;
      err_underflow <= 1'b0;
      tx_valid      <= 1'b0;
      tx_data       <= 16'h0000;
      rd_data_r     <= 16'h0000;
      rx_level      <= 5'd0;
      rx_full       <= 1'b0;
    end else begin
      if (addr_stb_s) begin
        last_addr <= wr_sd_r;
        be_bad_r  <= ~be_legal(wr_sd_r[15:12]);
        if (!be_legal(wr_sd_r[15:12])) be_err <= 1'b1;
      end
      if (underflow_s) err_underflow <= 1'b1;
      tx_valid <= data_wr_s && (offset_s == DATA_PORT);
      if (data_wr_s && (offset_s == DATA_PORT)) tx_data <= wr_sd_r;
      rd_data_r <= rd_word_s;
      rx_level  <= level_nxt_s;
      rx_full   <= (level_nxt_s == 5'd16);
    end
  end

  // Register storage; CHIP_ID lives in the low half of dword 48 and is never written.
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) begin
        mem_r[i] <= (i == 48) ? {16'h0000, CHIP_ID} : 32'h0000_0000;
      end
    end else if (data_wr_s && (offset_s != CHIP_OFS) && (offset_s != DATA_PORT)) begin
      if (lo_en_s) mem_r[idx_s][{hi_s, 4'b0000} +: 8] <= wr_sd_r[7:0];
      if (hi_en_s) mem_r[idx_s][{hi_s, 4'b1000} +: 8] <= wr_sd_r[15:8];
    end
  end

  // RX FIFO storage and pointers.
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        fifo_r[i] <= 16'h0000;
      end
      wptr_r <= 4'd0;
      rptr_r <= 4'd0;
    end else begin
      if (push_s) begin
        fifo_r[wptr_r] <= rx_data;
        wptr_r         <= wptr_r + 4'd1;
      end
      if (pop_s) rptr_r <= rptr_r + 4'd1;
    end
  end

endmodule
